// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: imem request/response, redirect input and the {pc, inst} hand-off to decode.
// The master modport is the fetch stage; the slave modport is memory, branch logic and decode together.
interface inst_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_inst,
    input  id_ready,
    output fetch_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_inst,
    output id_ready,
    input  fetch_err
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues in-order word fetches and buffers the returned words
// for decode; a redirect flushes the buffer and drops every response still in flight.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      slot_pc   [FIFO_DEPTH];
  logic [31:0]      slot_inst [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_full;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic             fetch_err_q;

  logic             req_fire;
  logic             pop;
  logic             rsp_take;
  logic             rsp_fill;
  logic             rsp_drop;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] redirect_discard;

  // A slot is reserved at accept time, so 'used' already covers both buffered and outstanding words.
  assign bus.imem_req_valid = (state == RUN) && !bus.redirect_valid && (used < DEPTH_C);
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = slot_full[rd_ptr];
  assign bus.if_pc          = slot_pc[rd_ptr];
  assign bus.if_inst        = slot_inst[rd_ptr];
  assign bus.fetch_err      = fetch_err_q;

  assign req_fire         = bus.imem_req_valid && bus.imem_req_ready;
  assign pop              = bus.if_valid && bus.id_ready;
  assign in_flight        = outstanding + discard;
  // Responses with nothing in flight (e.g. stale ones across a reset) are ignored.
  assign rsp_take         = bus.imem_rsp_valid && (in_flight != '0);
  assign rsp_fill         = rsp_take && (discard == '0) && !bus.redirect_valid;
  assign rsp_drop         = rsp_take && (discard != '0) && !bus.redirect_valid;
  assign redirect_discard = in_flight - CNT_W'(rsp_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      slot_full   <= '0;
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_inst[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Everything still in flight becomes discard; the FIFO restarts empty at the new PC.
      pc          <= {bus.redirect_pc[31:2], 2'b00};
      fetch_err_q <= fetch_err_q | (bus.redirect_pc[1:0] != 2'b00);
      slot_full   <= '0;
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      used        <= '0;
      outstanding <= '0;
      discard     <= redirect_discard;
      state       <= (redirect_discard != '0) ? FLUSH : RUN;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        FLUSH:   if (rsp_drop && (discard == CNT_W'(1))) state <= RUN;
        default: state <= BOOT;
      endcase

      if (req_fire) begin
        slot_pc[wr_ptr] <= pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
        pc              <= pc + 32'd4;
      end

      if (rsp_fill) begin
        slot_inst[fill_ptr] <= bus.imem_rsp_data;
        slot_full[fill_ptr] <= 1'b1;
        fill_ptr            <= fill_ptr + PTR_W'(1);
      end

      if (pop) begin
        slot_full[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end

      used        <= used + CNT_W'(req_fire) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fill);
      discard     <= discard - CNT_W'(rsp_drop);
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: an in-order memory model with configurable latency feeds a
// scoreboard of expected {pc, inst}; redirect vectors come from a table, corner cases are hand sequences.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] target; logic [31:0] exp_addr; logic exp_err; int lat; } redir_vec_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] fire_addrs[$];
  redir_vec_t  vecs[6];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          lat          = 1;
  int          rdy_mode     = 1;
  int          id_mode      = 1;
  bit          redir_req    = 1'b0;
  logic [31:0] redir_target = '0;
  bit          collide_mode = 1'b0;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_fire;
  logic        s_if_valid;
  logic [31:0] s_if_pc;
  logic        s_pop;
  logic        s_redirect;
  logic        s_fetch_err;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = '0;
  int          fire_count = 0;
  logic [31:0] last_fire_addr = '0;
  logic [31:0] first_pop_pc   = '0;
  bit          first_pop_seen = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    checkOutput({tag, "_req_addr"},  bus.imem_req_addr, RESET_PC);
    checkOutput({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
    checkOutput({tag, "_if_pc"},     bus.if_pc, 32'd0);
    checkOutput({tag, "_if_inst"},   bus.if_inst, 32'd0);
    checkOutput({tag, "_fetch_err"}, 32'(bus.fetch_err), 32'd0);
  endtask

  task automatic clearModel();
    pend_q.delete();
    exp_q.delete();
    fire_addrs.delete();
    fire_count     = 0;
    prev_stall     = 1'b0;
    first_pop_seen = 1'b0;
    redir_req      = 1'b0;
    collide_mode   = 1'b0;
  endtask

  task automatic doReset();
    rst                = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    clearModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
  endtask

  // One clock cycle: drive inputs at the falling edge, sample, update the models, advance.
  task automatic applyStimulus();
    exp_t e;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    bus.imem_req_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    bus.id_ready       = (id_mode == 2)  ? 1'($urandom_range(0, 1)) : 1'(id_mode);
    bus.redirect_pc    = redir_target;
    bus.redirect_valid = redir_req ||
                         (collide_mode && bus.if_valid && bus.imem_rsp_valid && bus.id_ready);
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_fetch_err = bus.fetch_err;
    s_fire      = s_req_valid && bus.imem_req_ready;
    s_pop       = s_if_valid && bus.id_ready;
    s_redirect  = bus.redirect_valid;

    if (s_req_valid) checkOutput("credit", 32'(exp_q.size() < DEPTH), 32'd1);
    if (prev_stall && s_req_valid) checkOutput("addr_stable", s_req_addr, prev_addr);

    if (s_pop) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL pop_unexpected: popped pc 0x%08h, expected no valid head (cycle %0d)", s_if_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("if_pc", s_if_pc, e.pc);
        checkOutput("if_inst", bus.if_inst, e.inst);
        if (!first_pop_seen) first_pop_pc = s_if_pc;
        first_pop_seen = 1'b1;
      end
    end
    if (s_redirect) begin
      exp_q.delete();
      first_pop_seen = 1'b0;
    end
    if (s_fire) begin
      pend_q.push_back('{s_req_addr, cyc + lat});
      exp_q.push_back('{s_req_addr, mem_word(s_req_addr)});
      fire_addrs.push_back(s_req_addr);
      fire_count++;
      last_fire_addr = s_req_addr;
    end
    prev_stall = s_req_valid && !bus.imem_req_ready;
    prev_addr  = s_req_addr;
    redir_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0;
    int k;
    int red_cyc;
    bit got;

    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0, 2};
    vecs[1] = '{32'h0000_0444, 32'h0000_0444, 1'b0, 3};
    vecs[2] = '{32'h0000_0202, 32'h0000_0200, 1'b1, 1};
    vecs[3] = '{32'h0000_03FC, 32'h0000_03FC, 1'b1, 2};
    vecs[4] = '{32'h0000_1001, 32'h0000_1000, 1'b1, 3};
    vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1};

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;

    // Reset state, then streaming with 1-cycle memory and decode always ready
    @(negedge clk);
    checkReset("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
    rdy_mode = 1; id_mode = 1; lat = 1;
    applyStimulus();
    checkOutput("t1_boot_noreq", 32'(s_req_valid), 32'd0);
    applyStimulus();
    checkOutput("t1_first_req_valid", 32'(s_req_valid), 32'd1);
    checkOutput("t1_first_req_addr", s_req_addr, 32'h0);
    applyStimulus();
    checkOutput("t1_no_bypass", 32'(s_if_valid), 32'd0);
    applyStimulus();
    checkOutput("t1_head_valid", 32'(s_if_valid), 32'd1);
    checkOutput("t1_head_pc", s_if_pc, 32'h0);
    repeat (30) applyStimulus();
    checkOutput("t1_progress", 32'(fire_count >= 10), 32'd1);

    // Decode stalled: exactly DEPTH requests, then one credit per pop
    doReset();
    id_mode = 0;
    repeat (12) applyStimulus();
    checkOutput("t2_req_count", 32'(fire_addrs.size()), 32'd2);
    if (fire_addrs.size() >= 2) begin
      checkOutput("t2_req0", fire_addrs[0], 32'h0);
      checkOutput("t2_req1", fire_addrs[1], 32'h4);
    end
    checkOutput("t2_full_noreq", 32'(s_req_valid), 32'd0);
    id_mode = 1;
    applyStimulus();
    id_mode = 0;
    n0 = fire_count;
    repeat (8) applyStimulus();
    checkOutput("t2_single_req", 32'(fire_count - n0), 32'd1);
    checkOutput("t2_single_addr", last_fire_addr, 32'h8);
    id_mode = 1;
    repeat (10) applyStimulus();

    // Redirect with two requests outstanding: both responses dropped, restart at 0x100
    doReset();
    lat = 4;
    repeat (3) applyStimulus();
    redir_req = 1'b1;
    redir_target = 32'h0000_0100;
    applyStimulus();
    repeat (3) begin
      applyStimulus();
      checkOutput("t3_flush_noreq", 32'(s_req_valid), 32'd0);
      checkOutput("t3_no_stale", 32'(s_if_valid), 32'd0);
    end
    applyStimulus();
    checkOutput("t3_restart_valid", 32'(s_req_valid), 32'd1);
    checkOutput("t3_restart_addr", s_req_addr, 32'h0000_0100);
    lat = 1;
    repeat (12) applyStimulus();
    checkOutput("t3_first_pop_seen", 32'(first_pop_seen), 32'd1);
    checkOutput("t3_first_if_pc", first_pop_pc, 32'h0000_0100);

    // Redirect colliding with a response and a pop
    doReset();
    lat = 1;
    collide_mode = 1'b1;
    redir_target = 32'h0000_0040;
    got = 1'b0;
    red_cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      red_cyc = cyc;
      applyStimulus();
      got = s_redirect;
    end
    collide_mode = 1'b0;
    checkOutput("t4_collision_seen", 32'(got), 32'd1);
    checkOutput("t4_collision_cycle", 32'(red_cyc), 32'd4);
    applyStimulus();
    checkOutput("t4_fifo_empty", 32'(s_if_valid), 32'd0);
    checkOutput("t4_req_valid", 32'(s_req_valid), 32'd1);
    checkOutput("t4_req_addr", s_req_addr, 32'h0000_0040);
    repeat (10) applyStimulus();

    // Redirect vectors under random memory and decode back-pressure
    doReset();
    rdy_mode = 2;
    id_mode  = 2;
    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      repeat (8) applyStimulus();
      redir_req    = 1'b1;
      redir_target = vecs[v].target;
      applyStimulus();
      applyStimulus();
      checkOutput("vec_fetch_err", 32'(s_fetch_err), 32'(vecs[v].exp_err));
      k = 0;
      while (!s_req_valid && k < 40) begin
        applyStimulus();
        k++;
      end
      checkOutput("vec_req_valid", 32'(s_req_valid), 32'd1);
      checkOutput("vec_req_addr", s_req_addr, vecs[v].exp_addr);
    end
    repeat (10) applyStimulus();

    // PC wrap at the top of the address space
    rdy_mode = 1;
    id_mode  = 1;
    lat      = 1;
    redir_req    = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    applyStimulus();
    n0 = fire_count;
    k  = 0;
    while (fire_count == n0 && k < 40) begin applyStimulus(); k++; end
    checkOutput("wrap_first_addr", last_fire_addr, 32'hFFFF_FFFC);
    n0 = fire_count;
    k  = 0;
    while (fire_count == n0 && k < 40) begin applyStimulus(); k++; end
    checkOutput("wrap_next_addr", last_fire_addr, 32'h0000_0000);
    applyStimulus();

    // Asynchronous reset between clock edges, then a clean restart
    #2;
    rst = 1'b1;
    #1;
    checkReset("async_rst");
    clearModel();
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
    applyStimulus();
    checkOutput("post_rst_boot", 32'(s_req_valid), 32'd0);
    applyStimulus();
    checkOutput("post_rst_req_valid", 32'(s_req_valid), 32'd1);
    checkOutput("post_rst_req_addr", s_req_addr, RESET_PC);
    repeat (10) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
